melody_seq_ctrl: RTL and testbench



---
 rtl/melody_pkg.sv | 29 ++
 rtl/melody_seq_ctrl_dur_timer.sv | 30 +++
 rtl/melody_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_melody_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer and its duration timer.
package melody_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    TONE  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_NOTES  = 8;
  localparam int DEF_NOTE_W = 4;
  localparam int NOTE_REST  = 0;

  // Address width for a store of n notes
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Counter width able to hold max(a, b) - 1
  function automatic int tmr_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/melody_seq_ctrl_dur_timer.sv
// Loadable down-counter with a zero flag; times both note and gap durations.
module dur_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Clear wins over load; otherwise count down and park at zero
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/melody_seq_ctrl.sv
// Melody sequencer: records keyed notes into the note store and plays them
// back on the piezo tone output, one note per FETCH/TONE/GAP round.
//
// Strobes: key_valid, play_req and clear_req are single-cycle requests with
// no ready/backpressure; they are acted on in the cycle they are sampled high
// or dropped (key_valid/play_req while busy, key_valid while full, play_req
// coinciding with key_valid). The store read port is registered: mem_rdata
// reflects mem_raddr as presented one cycle earlier.
module melody_seq_ctrl
  import melody_pkg::*;
#(
  parameter int NOTES          = DEF_NOTES,
  parameter int NOTE_W         = DEF_NOTE_W,
  parameter int TICKS_PER_NOTE = 5000000,
  parameter int GAP_TICKS      = 500000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       key_valid,
  input  logic [NOTE_W-1:0]          key_note,
  input  logic                       play_req,
  input  logic                       clear_req,
  output logic                       mem_we,
  output logic [addr_w(NOTES)-1:0]   mem_waddr,
  output logic [NOTE_W-1:0]          mem_wdata,
  output logic [addr_w(NOTES)-1:0]   mem_raddr,
  input  logic [NOTE_W-1:0]          mem_rdata,
  output logic [addr_w(NOTES):0]     note_count,
  output logic                       full,
  output logic [NOTE_W-1:0]          tone_out,
  output logic                       tone_en,
  output logic                       busy,
  output logic                       play_done,
  output state_t                     dbg_state
);

  localparam int AW = addr_w(NOTES);
  localparam int CW = AW + 1;
  localparam int TW = tmr_w(TICKS_PER_NOTE, GAP_TICKS);

  localparam logic [TW-1:0]     TONE_LOAD = TW'(TICKS_PER_NOTE - 1);
  localparam logic [TW-1:0]     GAP_LOAD  = (GAP_TICKS > 0) ? TW'(GAP_TICKS - 1) : '0;
  localparam logic [CW-1:0]     COUNT_MAX = CW'(NOTES);
  localparam logic [NOTE_W-1:0] REST_CODE = NOTE_W'(NOTE_REST);

  // Registered state and outputs
  state_t            r_state;
  logic [AW-1:0]     r_idx;
  logic [CW-1:0]     r_count;
  logic              r_full;
  logic              r_mem_we;
  logic [AW-1:0]     r_mem_waddr;
  logic [NOTE_W-1:0] r_mem_wdata;
  logic [AW-1:0]     r_mem_raddr;
  logic [NOTE_W-1:0] r_tone_out;
  logic              r_tone_en;
  logic              r_busy;
  logic              r_play_done;

  // Next-state values
  state_t            w_state_nxt;
  logic [AW-1:0]     w_idx_nxt;
  logic [CW-1:0]     w_count_nxt;
  logic              w_we_nxt;
  logic [AW-1:0]     w_waddr_nxt;
  logic [NOTE_W-1:0] w_wdata_nxt;
  logic [AW-1:0]     w_raddr_nxt;
  logic [NOTE_W-1:0] w_tone_out_nxt;
  logic              w_tone_en_nxt;
  logic              w_done_nxt;
  logic              w_tmr_load;
  logic [TW-1:0]     w_tmr_val;
  logic              w_tmr_clr;
  logic              w_tmr_zero;
  logic              w_last_note;

  dur_timer #(
    .W (TW)
  ) u_dur_timer (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_clr      (w_tmr_clr),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  // note_count is at least 1 whenever playback runs, so the subtraction is safe
  assign w_last_note = ({1'b0, r_idx} == (r_count - CW'(1)));

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_count_nxt    = r_count;
    w_we_nxt       = 1'b0;
    w_waddr_nxt    = r_mem_waddr;
    w_wdata_nxt    = r_mem_wdata;
    w_raddr_nxt    = r_mem_raddr;
    w_tone_out_nxt = r_tone_out;
    w_tone_en_nxt  = r_tone_en;
    w_done_nxt     = 1'b0;
    w_tmr_load     = 1'b0;
    w_tmr_val      = '0;
    w_tmr_clr      = 1'b0;

    if (clear_req && (r_state != IDLE)) begin
      // Abort: silence immediately, forget the melody, drop any in-flight read
      w_state_nxt    = IDLE;
      w_count_nxt    = '0;
      w_idx_nxt      = '0;
      w_raddr_nxt    = '0;
      w_tone_out_nxt = '0;
      w_tone_en_nxt  = 1'b0;
      w_tmr_clr      = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (clear_req) begin
            w_count_nxt = '0;
          end else if (key_valid) begin
            if (!r_full) begin
              w_we_nxt    = 1'b1;
              w_waddr_nxt = r_count[AW-1:0];
              w_wdata_nxt = key_note;
              w_count_nxt = r_count + CW'(1);
            end
          end else if (play_req) begin
            if (r_count == '0) begin
              w_done_nxt = 1'b1;
            end else begin
              // raddr already sits at 0 in IDLE, so note 0 is ready during FETCH
              w_idx_nxt   = '0;
              w_raddr_nxt = '0;
              w_state_nxt = FETCH;
            end
          end
        end

        FETCH: begin
          w_tone_out_nxt = mem_rdata;
          w_tone_en_nxt  = (mem_rdata != REST_CODE);
          w_tmr_load     = 1'b1;
          w_tmr_val      = TONE_LOAD;
          // Prefetch the following note so it is readable by the next FETCH
          w_raddr_nxt    = r_idx + AW'(1);
          w_state_nxt    = TONE;
        end

        TONE: begin
          if (w_tmr_zero) begin
            w_tone_en_nxt = 1'b0;
            if (GAP_TICKS > 0) begin
              w_tmr_load  = 1'b1;
              w_tmr_val   = GAP_LOAD;
              w_state_nxt = GAP;
            end else if (w_last_note) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = DONE;
            end else begin
              w_idx_nxt   = r_idx + AW'(1);
              w_state_nxt = FETCH;
            end
          end
        end

        GAP: begin
          if (w_tmr_zero) begin
            if (w_last_note) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = DONE;
            end else begin
              w_idx_nxt   = r_idx + AW'(1);
              w_state_nxt = FETCH;
            end
          end
        end

        DONE: begin
          w_tone_out_nxt = '0;
          w_raddr_nxt    = '0;
          w_idx_nxt      = '0;
          w_state_nxt    = IDLE;
        end

        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx       <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
      r_mem_raddr <= '0;
      r_tone_out  <= '0;
      r_tone_en   <= 1'b0;
      r_busy      <= 1'b0;
      r_play_done <= 1'b0;
    end else begin
      r_idx       <= w_idx_nxt;
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == COUNT_MAX);
      r_mem_we    <= w_we_nxt;
      r_mem_waddr <= w_waddr_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_mem_raddr <= w_raddr_nxt;
      r_tone_out  <= w_tone_out_nxt;
      r_tone_en   <= w_tone_en_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      r_play_done <= w_done_nxt;
    end
  end

  assign mem_we     = r_mem_we;
  assign mem_waddr  = r_mem_waddr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_raddr  = r_mem_raddr;
  assign note_count = r_count;
  assign full       = r_full;
  assign tone_out   = r_tone_out;
  assign tone_en    = r_tone_en;
  assign busy       = r_busy;
  assign play_done  = r_play_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_melody_seq_ctrl.sv
// Directed bench for melody_seq_ctrl with a small registered-read note store.
module tb_melody_seq_ctrl;
  import melody_pkg::*;

  localparam int NOTES  = 8;
  localparam int NOTE_W = 4;
  localparam int TPN    = 4;
  localparam int GAPT   = 2;
  localparam int PER    = TPN + GAPT + 1;

  logic              clk;
  logic              reset;
  logic              key_valid;
  logic [NOTE_W-1:0] key_note;
  logic              play_req;
  logic              clear_req;
  logic              mem_we;
  logic [2:0]        mem_waddr;
  logic [NOTE_W-1:0] mem_wdata;
  logic [2:0]        mem_raddr;
  logic [NOTE_W-1:0] mem_rdata;
  logic [3:0]        note_count;
  logic              full;
  logic [NOTE_W-1:0] tone_out;
  logic              tone_en;
  logic              busy;
  logic              play_done;
  state_t            dbg_state;

  logic [NOTE_W-1:0] mem [NOTES];
  logic [NOTE_W-1:0] exp_notes [NOTES];

  int total    = 0;
  int bad      = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;

  melody_seq_ctrl #(
    .NOTES          (NOTES),
    .NOTE_W         (NOTE_W),
    .TICKS_PER_NOTE (TPN),
    .GAP_TICKS      (GAPT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_note   (key_note),
    .play_req   (play_req),
    .clear_req  (clear_req),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .note_count (note_count),
    .full       (full),
    .tone_out   (tone_out),
    .tone_en    (tone_en),
    .busy       (busy),
    .play_done  (play_done),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Note store: write port plus registered read port
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_rdata <= mem[mem_raddr];
  end

  // Event counters sampled on the falling edge
  always @(negedge clk) begin
    if (mem_we === 1'b1) wr_cnt = wr_cnt + 1;
    if (play_done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic key(input logic [NOTE_W-1:0] n);
    key_valid = 1'b1;
    key_note  = n;
    tick(1);
    key_valid = 1'b0;
  endtask

  task automatic clear_melody();
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    chk("clear_count", note_count, 0);
  endtask

  // Play exp_notes[0..n-1] and check every cycle; pokes key/play mid-run
  task automatic run_play(input int n);
    int last;
    int k;
    int p;
    int wr0;
    logic exp_en;
    wr0  = wr_cnt;
    last = PER * n;
    play_req = 1'b1;
    tick(1);
    play_req = 1'b0;
    chk("fetch_busy", busy, 1);
    chk("fetch_tone_en", tone_en, 0);
    for (int c = 1; c <= last + 1; c++) begin
      if (c == 5) begin
        key_valid = 1'b1;
        key_note  = 4'd9;
        play_req  = 1'b1;
      end
      tick(1);
      key_valid = 1'b0;
      play_req  = 1'b0;
      if (c < last) begin
        k = (c - 1) / PER;
        p = (c - 1) % PER;
        exp_en = (p < TPN) && (exp_notes[k] != 4'd0);
        chk("play_tone_en", tone_en, exp_en);
        if (p < TPN) chk("play_tone_out", tone_out, exp_notes[k]);
      end
      chk("play_done", play_done, (c == last));
      chk("play_busy", busy, (c <= last));
    end
    chk("play_no_write", wr_cnt, wr0);
  endtask

  initial begin
    reset     = 1'b1;
    key_valid = 1'b0;
    key_note  = '0;
    play_req  = 1'b0;
    clear_req = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < NOTES; i++) mem[i] = '0;

    // Reset state
    tick(2);
    chk("rst_state", dbg_state, IDLE);
    chk("rst_count", note_count, 0);
    chk("rst_full", full, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_raddr", mem_raddr, 0);
    chk("rst_tone_en", tone_en, 0);
    chk("rst_tone_out", tone_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", play_done, 0);
    reset = 1'b0;
    tick(1);

    // Record 3, 5, 7
    exp_notes[0] = 4'd3;
    exp_notes[1] = 4'd5;
    exp_notes[2] = 4'd7;
    for (int i = 0; i < 3; i++) begin
      key(exp_notes[i]);
      chk("rec_we", mem_we, 1);
      chk("rec_waddr", mem_waddr, i);
      chk("rec_wdata", mem_wdata, exp_notes[i]);
      chk("rec_count", note_count, i + 1);
    end
    tick(1);
    chk("rec_we_low", mem_we, 0);
    chk("rec_full", full, 0);

    // Play 3, 5, 7 with key/play pokes ignored mid-run
    run_play(3);
    chk("after_play_count", note_count, 3);

    // Fill past capacity
    clear_melody();
    for (int i = 0; i < 9; i++) begin
      key(NOTE_W'(i + 1));
      if (i < 8) begin
        chk("fill_we", mem_we, 1);
        chk("fill_waddr", mem_waddr, i);
        chk("fill_wdata", mem_wdata, i + 1);
        chk("fill_count", note_count, i + 1);
        chk("fill_full", full, (i == 7));
      end else begin
        chk("ovf_we", mem_we, 0);
        chk("ovf_count", note_count, 8);
        chk("ovf_full", full, 1);
      end
    end
    tick(1);

    // Rest note in the middle
    clear_melody();
    exp_notes[0] = 4'd4;
    exp_notes[1] = 4'd0;
    exp_notes[2] = 4'd6;
    for (int i = 0; i < 3; i++) key(exp_notes[i]);
    tick(1);
    chk("rest_count", note_count, 3);
    run_play(3);

    // Abort during the second note
    clear_melody();
    key(4'd3);
    key(4'd5);
    tick(1);
    play_req = 1'b1;
    tick(1);
    play_req = 1'b0;
    tick(9);
    chk("abort_pre_en", tone_en, 1);
    chk("abort_pre_out", tone_out, 5);
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    chk("abort_state", dbg_state, IDLE);
    chk("abort_busy", busy, 0);
    chk("abort_tone_en", tone_en, 0);
    chk("abort_tone_out", tone_out, 0);
    chk("abort_count", note_count, 0);
    chk("abort_done", play_done, 0);
    tick(3);
    chk("abort_done_cnt", done_cnt, 2);
    chk("abort_idle", busy, 0);

    // Play with an empty melody
    play_req = 1'b1;
    tick(1);
    play_req = 1'b0;
    chk("empty_done", play_done, 1);
    chk("empty_busy", busy, 0);
    tick(1);
    chk("empty_done_low", play_done, 0);
    chk("empty_busy2", busy, 0);

    // Asynchronous reset mid-tone
    key(4'd7);
    key(4'd9);
    tick(1);
    play_req = 1'b1;
    tick(1);
    play_req = 1'b0;
    tick(2);
    chk("mid_tone_en", tone_en, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_tone_en", tone_en, 0);
    chk("arst_tone_out", tone_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", note_count, 0);
    chk("arst_state", dbg_state, IDLE);
    tick(1);
    reset = 1'b0;
    tick(2);

    // Totals over the whole run
    chk("total_writes", wr_cnt, 18);
    chk("total_done", done_cnt, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
